truth_table_sweeper: RTL and testbench
======================================

# truth_table_sweeper

Sequential stimulus-and-capture stage that sits directly upstream of the 4-input combinational function blocks (x, y, w, z → s). On a start request it drives all 16 input combinations in ascending order onto the function inputs. It samples the function output `s` for each combination and assembles a 16-bit truth-table signature. It then compares that signature against an expected word, replacing the hand-written `#1` stimulus sequences with a reusable in-circuit checker.

## Interface
Parameters:
- `STEP_CYCLES`, default 1: cycles each vector is held before its output is sampled; legal range 1..255.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  begin a sweep; sampled only in IDLE.
- `abort`  in  1  synchronous cancel; return to IDLE, results untouched.
- `expected`  in  16  reference signature; sampled on the same edge as `start` is accepted.
- `s_in`  in  1  output of the function under test.
- `x`, `y`, `w`, `z`  out  1 each  drive to the function under test; {x,y,w,z} = vector index bits [3:0].
- `busy`  out  1  high while sweeping.
- `done`  out  1  one-cycle pulse when a sweep completes.
- `table_out`  out  16  bit i = s_in captured for vector i; valid from `done` until the next completion.
- `ones_count`  out  5  number of 1 bits in `table_out` (0..16).
- `pass`  out  1  `table_out == expected` for the last completed sweep.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: `start` → RUN. Latch `expected`. Clear the working table and ones counter. Set idx=0, step=0.
  - RUN: each cycle step++.
    - When step == STEP_CYCLES-1:
      - Write `s_in` into work[idx].
      - Add `s_in` to the running count.
      - Reset step.
      - If idx==15 → DONE; else idx++.
  - DONE (one cycle):
    - Copy work into `table_out`.
    - Copy the count into `ones_count`.
    - Set `pass` = (work == latched expected).
    - Assert `done`.
    - Go to IDLE.
- `abort` in RUN → IDLE next edge. `table_out`, `ones_count` and `pass` keep their previous values. `done` is not asserted. `abort` in IDLE or DONE has no effect.
- `abort` and the last-sample edge in the same cycle: `abort` wins, and the sweep is discarded.
- `start` in RUN or DONE is ignored. No queuing.
- `start` in the same IDLE cycle as `done` being low is the normal case. Back-to-back sweeps are allowed: `start` asserted in the IDLE cycle following DONE.
- The x/y/w/z outputs are registered from idx. They are 0000 in IDLE and DONE.
- Width rules:
  - idx is 4 bits and never wraps inside a sweep.
  - step is 8 bits.
  - The running count is 5 bits and cannot overflow (max 16).

## Timing
- Reset values:
  - State IDLE.
  - x=y=w=z=0.
  - busy=0, done=0.
  - table_out=16'h0000.
  - ones_count=0.
  - pass=0.
- Reset asserted mid-sweep forces the reset values immediately, with no completion pulse.
- `start` accepted at edge T:
  - busy=1 and vector 0 is driven from T+1.
  - Vector k is driven during cycles T+1+k·STEP_CYCLES … T+(k+1)·STEP_CYCLES.
  - Vector k is sampled on the last of those edges.
- `done`=1 in cycle T+1+16·STEP_CYCLES. `busy` is low in that cycle.
- Results are visible in the same cycle as `done`.
- `s_in` must settle within STEP_CYCLES cycles of a vector change. STEP_CYCLES=1 means one full cycle of combinational settle.

## Structure
- Shared package `sweeper_pkg`:
  - state enum {IDLE, RUN, DONE}
  - `NUM_VECTORS`=16
  - `IDX_W`=4
  - `CNT_W`=5
- One natural sub-module: `sweep_step_timer`. It holds the step counter and idx counter, with inputs clear/enable and outputs `sample_en` and `last_vector`. The FSM, capture register and compare logic stay in the top.

## Test plan
- Reset, then `start` with STEP_CYCLES=1 against s = x·w' + y·w'·z' + x·y·z', with expected=16'h7310 → done at T+17, table_out=16'h7310, ones_count=6, pass=1.
- Same function, expected=16'h7311 → table_out=16'h7310, pass=0.
- STEP_CYCLES=3 with s_in tied to 1 → each vector held 3 cycles, done at T+49, table_out=16'hFFFF, ones_count=16.
- Assert `abort` during vector 7 after a prior passing sweep → IDLE next cycle, no `done`, table_out and pass unchanged, x/y/w/z=0000.
- `start` pulsed during RUN and `rst_n` dropped during vector 9 → the extra start is ignored; on reset all outputs return to their reset values asynchronously.
- Back-to-back: `start` in the first IDLE cycle after `done` → the second sweep completes 17 cycles later with identical results.

Source files
------------

// File: rtl/truth_table_sweeper_pkg.sv
`default_nettype none
// ==========================================================================
// sweeper_pkg : shared types and widths for the truth-table sweeper (rev 1.0)
// ==========================================================================
package sweeper_pkg;

  localparam int NUM_VECTORS = 16;
  localparam int IDX_W       = 4;
  localparam int CNT_W       = 5;
  localparam int STEP_W      = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/truth_table_sweeper_if.sv
`default_nettype none
// ==========================================================================
// truth_table_sweeper_if : control, function-under-test and result signals (rev 1.0)
// ==========================================================================
interface truth_table_sweeper_if;
  import sweeper_pkg::*;

  logic                   start;
  logic                   abort;
  logic [NUM_VECTORS-1:0] expected;
  logic                   s_in;
  logic                   x;
  logic                   y;
  logic                   w;
  logic                   z;
  logic                   busy;
  logic                   done;
  logic [NUM_VECTORS-1:0] table_out;
  logic [CNT_W-1:0]       ones_count;
  logic                   pass;

  modport master (
    output start, abort, expected, s_in,
    input  x, y, w, z, busy, done, table_out, ones_count, pass
  );

  modport slave (
    input  start, abort, expected, s_in,
    output x, y, w, z, busy, done, table_out, ones_count, pass
  );

endinterface
`default_nettype wire

// File: rtl/truth_table_sweeper_sweep_step_timer.sv
`default_nettype none
// ==========================================================================
// sweep_step_timer : per-vector hold counter and vector index (rev 1.0)
// ==========================================================================
module sweep_step_timer
  import sweeper_pkg::*;
#(
  parameter int STEP_CYCLES = 1
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             clear,
  input  wire logic             enable,
  output logic                  sample_en,
  output logic                  last_vector,
  output logic [IDX_W-1:0]      idx
);

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

  logic [STEP_W-1:0] step;

  // idx doubles as the registered vector drive, so it is held at zero outside a sweep
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step <= '0;
      idx  <= '0;
    end else if (clear) begin
      step <= '0;
      idx  <= '0;
    end else if (enable) begin
      if (step == STEP_LAST) begin
        step <= '0;
        idx  <= idx + 1'b1;
      end else begin
        step <= step + 1'b1;
      end
    end
  end

  assign sample_en   = enable && (step == STEP_LAST);
  assign last_vector = (idx == IDX_W'(NUM_VECTORS - 1));

endmodule
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ==========================================================================
// truth_table_sweeper : sweeps 16 input vectors, captures s_in, checks signature (rev 1.0)
// ==========================================================================
module truth_table_sweeper
  import sweeper_pkg::*;
#(
  parameter int STEP_CYCLES = 1
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  truth_table_sweeper_if.slave    bus
);

  state_t                 state;
  state_t                 state_nxt;
  logic                   sample_en;
  logic                   last_vector;
  logic [IDX_W-1:0]       idx;
  logic [NUM_VECTORS-1:0] work;
  logic [NUM_VECTORS-1:0] work_nxt;
  logic [NUM_VECTORS-1:0] exp_q;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic [NUM_VECTORS-1:0] table_q;
  logic [CNT_W-1:0]       ones_q;
  logic                   pass_q;
  logic                   capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = RUN;
      RUN: begin
        if (bus.abort) begin
          state_nxt = IDLE;
        end else if (sample_en && last_vector) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  sweep_step_timer #(
    .STEP_CYCLES (STEP_CYCLES)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (state_nxt != RUN),
    .enable      (state == RUN),
    .sample_en   (sample_en),
    .last_vector (last_vector),
    .idx         (idx)
  );

  // abort on the final sample edge must discard the sweep, hence the !abort gate
  assign capture = (state == RUN) && !bus.abort && sample_en;

  always_comb begin
    work_nxt      = work;
    work_nxt[idx] = bus.s_in;
    cnt_nxt       = cnt + CNT_W'(bus.s_in);
  end

  // results are committed on the last sample edge so they are visible alongside done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q   <= '0;
      work    <= '0;
      cnt     <= '0;
      table_q <= '0;
      ones_q  <= '0;
      pass_q  <= 1'b0;
    end else if ((state == IDLE) && bus.start) begin
      exp_q <= bus.expected;
      work  <= '0;
      cnt   <= '0;
    end else if (capture) begin
      work <= work_nxt;
      cnt  <= cnt_nxt;
      if (last_vector) begin
        table_q <= work_nxt;
        ones_q  <= cnt_nxt;
        pass_q  <= (work_nxt == exp_q);
      end
    end
  end

  assign {bus.x, bus.y, bus.w, bus.z} = idx;
  assign bus.busy       = (state == RUN);
  assign bus.done       = (state == DONE);
  assign bus.table_out  = table_q;
  assign bus.ones_count = ones_q;
  assign bus.pass       = pass_q;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ==========================================================================
// tb_truth_table_sweeper : directed checks of sweep timing, capture, abort and reset (rev 1.0)
// ==========================================================================
module tb_truth_table_sweeper;
  import sweeper_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   applied     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  truth_table_sweeper_if bus1 ();
  truth_table_sweeper_if bus3 ();

  truth_table_sweeper #(.STEP_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  truth_table_sweeper #(.STEP_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  // s = x.w' + y.w'.z' + x.y.z' with {x,y,w,z} = vector bits [3:0]
  function automatic logic f_ref(input logic [3:0] v);
    return (v[3] & ~v[1]) | (v[2] & ~v[1] & ~v[0]) | (v[3] & v[2] & ~v[0]);
  endfunction

  assign bus1.s_in = f_ref({bus1.x, bus1.y, bus1.w, bus1.z});
  assign bus3.s_in = 1'b1;

  wire [3:0] vec1 = {bus1.x, bus1.y, bus1.w, bus1.z};
  wire [3:0] vec3 = {bus3.x, bus3.y, bus3.w, bus3.z};

  task automatic start1(input logic [15:0] e);
    @(negedge clk);
    bus1.expected = e;
    bus1.start    = 1'b1;
    @(posedge clk);
    #1 bus1.start = 1'b0;
  endtask

  task automatic wait_done1(output int n);
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (bus1.done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus1.start = 1'b0; bus1.abort = 1'b0; bus1.expected = '0;
    bus3.start = 1'b0; bus3.abort = 1'b0; bus3.expected = '0;
    repeat (3) @(negedge clk);
    applied++;
    if ({bus1.busy, bus1.done, bus1.pass, vec1, bus1.table_out, bus1.ones_count} !== 28'h0) begin
      miscompares++;
      $display("FAIL reset1: busy=%b done=%b pass=%b vec=%h table=%h ones=%0d, required all zero",
               bus1.busy, bus1.done, bus1.pass, vec1, bus1.table_out, bus1.ones_count);
    end
    applied++;
    if ({bus3.busy, bus3.done, bus3.pass, vec3, bus3.table_out, bus3.ones_count} !== 28'h0) begin
      miscompares++;
      $display("FAIL reset3: busy=%b done=%b pass=%b vec=%h table=%h ones=%0d, required all zero",
               bus3.busy, bus3.done, bus3.pass, vec3, bus3.table_out, bus3.ones_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sweep_pass();
    start1(16'h7310);
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      applied++;
      if (i < 17) begin
        if (bus1.busy !== 1'b1 || bus1.done !== 1'b0 || vec1 !== 4'(i - 1)) begin
          miscompares++;
          $display("FAIL pass_run cyc%0d: busy=%b done=%b vec=%h, required busy=1 done=0 vec=%h",
                   i, bus1.busy, bus1.done, vec1, 4'(i - 1));
        end
      end else begin
        if (bus1.done !== 1'b1 || bus1.busy !== 1'b0 || vec1 !== 4'h0 ||
            bus1.table_out !== 16'h7310 || bus1.ones_count !== 5'd6 || bus1.pass !== 1'b1) begin
          miscompares++;
          $display("FAIL pass_done: done=%b busy=%b vec=%h table=%h ones=%0d pass=%b, required 1 0 0 7310 6 1",
                   bus1.done, bus1.busy, vec1, bus1.table_out, bus1.ones_count, bus1.pass);
        end
      end
    end
    @(negedge clk);
    applied++;
    if (bus1.done !== 1'b0 || bus1.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL pass_pulse: done=%b busy=%b, required 0 0", bus1.done, bus1.busy);
    end
  endtask

  task automatic test_sweep_fail();
    int n;
    start1(16'h7311);
    wait_done1(n);
    applied++;
    if (n != 17 || bus1.table_out !== 16'h7310 || bus1.ones_count !== 5'd6 || bus1.pass !== 1'b0) begin
      miscompares++;
      $display("FAIL fail_sweep: done_cyc=%0d table=%h ones=%0d pass=%b, required 17 7310 6 0",
               n, bus1.table_out, bus1.ones_count, bus1.pass);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    start1(16'h7310);
    wait_done1(n);
    applied++;
    if (n != 17 || bus1.pass !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first: done_cyc=%0d pass=%b, required 17 1", n, bus1.pass);
    end
    start1(16'h7310);
    wait_done1(n);
    applied++;
    if (n != 17 || bus1.table_out !== 16'h7310 || bus1.ones_count !== 5'd6 || bus1.pass !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_second: done_cyc=%0d table=%h ones=%0d pass=%b, required 17 7310 6 1",
               n, bus1.table_out, bus1.ones_count, bus1.pass);
    end
  endtask

  task automatic test_abort();
    int seen;
    start1(16'h7311);
    for (int i = 1; i <= 8; i++) @(negedge clk);
    applied++;
    if (vec1 !== 4'h7 || bus1.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_pre: vec=%h busy=%b, required 7 1", vec1, bus1.busy);
    end
    bus1.abort = 1'b1;
    @(posedge clk);
    #1 bus1.abort = 1'b0;
    @(negedge clk);
    applied++;
    if (bus1.busy !== 1'b0 || bus1.done !== 1'b0 || vec1 !== 4'h0 ||
        bus1.table_out !== 16'h7310 || bus1.ones_count !== 5'd6 || bus1.pass !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_mid: busy=%b done=%b vec=%h table=%h ones=%0d pass=%b, required 0 0 0 7310 6 1",
               bus1.busy, bus1.done, vec1, bus1.table_out, bus1.ones_count, bus1.pass);
    end
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus1.done) seen++;
    end
    applied++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL abort_nodone: done pulses=%0d, required 0", seen);
    end
    // abort coinciding with the final sample edge
    start1(16'h7311);
    for (int i = 1; i <= 16; i++) @(negedge clk);
    bus1.abort = 1'b1;
    @(posedge clk);
    #1 bus1.abort = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus1.done) seen++;
    end
    applied++;
    if (seen != 0 || bus1.pass !== 1'b1 || bus1.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_last: done pulses=%0d pass=%b busy=%b, required 0 1 0", seen, bus1.pass, bus1.busy);
    end
  endtask

  task automatic test_step3();
    @(negedge clk);
    bus3.expected = 16'hFFFF;
    bus3.start    = 1'b1;
    @(posedge clk);
    #1 bus3.start = 1'b0;
    for (int i = 1; i <= 49; i++) begin
      @(negedge clk);
      applied++;
      if (i < 49) begin
        if (bus3.busy !== 1'b1 || bus3.done !== 1'b0 || vec3 !== 4'((i - 1) / 3)) begin
          miscompares++;
          $display("FAIL step3_run cyc%0d: busy=%b done=%b vec=%h, required 1 0 %h",
                   i, bus3.busy, bus3.done, vec3, 4'((i - 1) / 3));
        end
      end else begin
        if (bus3.done !== 1'b1 || bus3.busy !== 1'b0 || bus3.table_out !== 16'hFFFF ||
            bus3.ones_count !== 5'd16 || bus3.pass !== 1'b1) begin
          miscompares++;
          $display("FAIL step3_done: done=%b busy=%b table=%h ones=%0d pass=%b, required 1 0 ffff 16 1",
                   bus3.done, bus3.busy, bus3.table_out, bus3.ones_count, bus3.pass);
        end
      end
    end
  endtask

  task automatic test_start_and_reset();
    start1(16'h7310);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 3) bus1.start = 1'b0;
      applied++;
      if (bus1.busy !== 1'b1 || vec1 !== 4'(i - 1)) begin
        miscompares++;
        $display("FAIL restart_ignored cyc%0d: busy=%b vec=%h, required 1 %h", i, bus1.busy, vec1, 4'(i - 1));
      end
      if (i == 2) bus1.start = 1'b1;
    end
    #2 rst_n = 1'b0;
    #1;
    applied++;
    if ({bus1.busy, bus1.done, bus1.pass, vec1, bus1.table_out, bus1.ones_count} !== 28'h0 ||
        {bus3.pass, bus3.table_out, bus3.ones_count} !== 22'h0) begin
      miscompares++;
      $display("FAIL async_reset: busy=%b done=%b pass=%b vec=%h table=%h ones=%0d table3=%h, required all zero",
               bus1.busy, bus1.done, bus1.pass, vec1, bus1.table_out, bus1.ones_count, bus3.table_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    applied++;
    if (bus1.busy !== 1'b0 || bus1.done !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset: busy=%b done=%b, required 0 0", bus1.busy, bus1.done);
    end
  endtask

  initial begin
    test_reset();
    test_sweep_pass();
    test_sweep_fail();
    test_back_to_back();
    test_abort();
    test_step3();
    test_start_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
